floppy_sd_responder: RTL and testbench

- Target side of the floppy sector-request protocol: serves per-drive sector read/write requests issued by the floppy track loader.
- Sits between the track loader and the host block-device interface (per-image sector service with a byte stream).
- Owns a 512-byte sector buffer, so the loader side always sees a gap-free 512-byte burst and the backing side always sees a gap-free 512-byte drain.

---
 rtl/floppy_sd_responder.sv | 256 +++++++++++++++++++++++++
 tb/tb_floppy_sd_responder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/floppy_sd_responder.sv
// floppy_sd_responder
// Target side of the floppy sector-request protocol. Accepts per-drive sector
// read/write requests from the track loader, moves one 512-byte sector to or
// from the backing block device and buffers it locally. The loader therefore
// sees a gap-free 512-byte burst, and the backing side sees a gap-free
// 512-byte drain.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   req_lba       sector number, sampled on accept
//   req_rd/req_wr per-drive request levels (bit0 = int, bit1 = ext)
//   busy, done    transfer in progress / one-cycle completion pulse
//   byte_addr     byte index for the read stream and the write gather
//   byte_en       rd_data valid (read stream only)
//   rd_data       sector byte to initiator
//   wr_data       sector byte from initiator, WR_LAT cycles after byte_addr
//   blk_lba       latched sector number to the backing store
//   blk_sel       one-hot image select
//   blk_rd/blk_wr backing read/write request
//   blk_ack       backing transfer active
//   blk_addr      backing byte index
//   blk_din       read byte from backing, strobed by blk_din_we
//   blk_dout      write byte to backing, buf[blk_addr] one cycle later
//   err           sticky ack-timeout flag, cleared on the next accept
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for a request
// RD_REQ    | blk_rd raised, waiting for blk_ack
// RD_FILL   | backing writes bytes into the buffer until blk_ack falls
// RD_STREAM | 512 cycles of byte_en with rd_data = buf[byte_addr]
// WR_GATHER | byte_addr 0..511, capture wr_data WR_LAT cycles later
// WR_REQ    | blk_wr raised, waiting for blk_ack
// WR_DRAIN  | blk_dout <= buf[blk_addr] until blk_ack falls
// FINISH    | done pulse; held requests are accepted here as on return to IDLE

module floppy_sd_responder #(
    parameter int WR_LAT      = 1,
    parameter int ACK_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] req_lba,
    input  logic [1:0]  req_rd,
    input  logic [1:0]  req_wr,
    output logic        busy,
    output logic        done,
    output logic [8:0]  byte_addr,
    output logic        byte_en,
    output logic [7:0]  rd_data,
    input  logic [7:0]  wr_data,
    output logic [10:0] blk_lba,
    output logic [1:0]  blk_sel,
    output logic        blk_rd,
    output logic        blk_wr,
    input  logic        blk_ack,
    input  logic [8:0]  blk_addr,
    input  logic [7:0]  blk_din,
    input  logic        blk_din_we,
    output logic [7:0]  blk_dout,
    output logic        err
);

    localparam int CNT_W = $clog2(512 + WR_LAT + 1);
    localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    localparam logic [CNT_W-1:0] LAST_BYTE   = CNT_W'(511);
    localparam logic [CNT_W-1:0] GATHER_LAST = CNT_W'(511 + WR_LAT);
    localparam logic [TMR_W-1:0] TMR_LOAD    = TMR_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_FILL,
        RD_STREAM,
        WR_GATHER,
        WR_REQ,
        WR_DRAIN,
        FINISH
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0] cnt, cnt_next;
    logic [TMR_W-1:0] tmr;
    logic [7:0]       mem [512];

    logic       any_req;
    logic       accept;
    logic       accept_rd;
    logic [1:0] accept_sel;
    logic [1:0] req_vec;
    logic       tmr_expired;
    logic       timeout;
    logic       fill_we;
    logic       gather_live;
    logic       cap_vld;
    logic [8:0] cap_addr;

    // Arbitration: any read beats any write, drive 0 beats drive 1.
    assign any_req    = |(req_rd | req_wr);
    assign accept_rd  = |req_rd;
    assign req_vec    = accept_rd ? req_rd : req_wr;
    assign accept_sel = req_vec[0] ? 2'b01 : {req_vec[1], 1'b0};

    // The down-counter only runs in the request states; ACK_TIMEOUT = 0 never expires.
    assign tmr_expired = (ACK_TIMEOUT > 0) && (tmr == '0);

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE, FINISH: begin
                if (any_req) begin
                    accept     = 1'b1;
                    state_next = accept_rd ? RD_REQ : WR_GATHER;
                end else begin
                    state_next = IDLE;
                end
            end
            RD_REQ: begin
                if (blk_ack) begin
                    state_next = RD_FILL;
                end else if (tmr_expired) begin
                    timeout    = 1'b1;
                    state_next = FINISH;
                end
            end
            RD_FILL: begin
                if (!blk_ack) state_next = RD_STREAM;
            end
            RD_STREAM: begin
                if (cnt == LAST_BYTE) state_next = FINISH;
            end
            WR_GATHER: begin
                if (cnt == GATHER_LAST) state_next = WR_REQ;
            end
            WR_REQ: begin
                if (blk_ack) begin
                    state_next = WR_DRAIN;
                end else if (tmr_expired) begin
                    timeout    = 1'b1;
                    state_next = FINISH;
                end
            end
            WR_DRAIN: begin
                if (!blk_ack) state_next = FINISH;
            end
            default: state_next = IDLE;
        endcase
    end

    // cnt is the cycle index inside RD_STREAM / WR_GATHER and restarts at 0 on entry.
    always_comb begin
        cnt_next = '0;
        if ((state == RD_STREAM || state == WR_GATHER) && state_next == state) begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    always_comb begin
        byte_addr = 9'd0;
        case (state)
            RD_STREAM: byte_addr = cnt[8:0];
            WR_GATHER: byte_addr = (cnt > LAST_BYTE) ? 9'd511 : cnt[8:0];
            default:   byte_addr = 9'd0;
        endcase
    end

    assign busy    = (state != IDLE) && (state != FINISH);
    assign done    = (state == FINISH);
    assign byte_en = (state == RD_STREAM);
    assign blk_rd  = (state == RD_REQ);
    assign blk_wr  = (state == WR_REQ);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            tmr     <= TMR_LOAD;
            err     <= 1'b0;
            blk_lba <= 11'd0;
            blk_sel <= 2'b00;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state == RD_REQ || state == WR_REQ) begin
                tmr <= tmr - TMR_W'(1);
            end else begin
                tmr <= TMR_LOAD;
            end
            if (accept) begin
                blk_lba <= req_lba;
                blk_sel <= accept_sel;
                err     <= 1'b0;
            end else if (timeout) begin
                err <= 1'b1;
            end
        end
    end

    // An ack already high in RD_REQ counts, so the fill may start in that cycle.
    assign fill_we     = blk_din_we && blk_ack && (state == RD_REQ || state == RD_FILL);
    assign gather_live = (state == WR_GATHER) && (cnt <= LAST_BYTE);

    generate
        if (WR_LAT == 0) begin : g_cap_direct
            assign cap_vld  = gather_live;
            assign cap_addr = byte_addr;
        end else begin : g_cap_pipe
            logic [WR_LAT-1:0] vld_sr;
            logic [8:0]        addr_sr [WR_LAT];

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_sr <= '0;
                end else begin
                    vld_sr[0] <= gather_live;
                    for (int i = 1; i < WR_LAT; i++) vld_sr[i] <= vld_sr[i-1];
                end
                addr_sr[0] <= byte_addr;
                for (int i = 1; i < WR_LAT; i++) addr_sr[i] <= addr_sr[i-1];
            end

            assign cap_vld  = vld_sr[WR_LAT-1];
            assign cap_addr = addr_sr[WR_LAT-1];
        end
    endgenerate

    // Fill and gather live in disjoint states, so one write port suffices.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            mem[blk_addr] <= blk_din;
        end else if (cap_vld) begin
            mem[cap_addr] <= wr_data;
        end
    end

    // rd_data is fetched with the address the counter will hold next cycle,
    // so byte_en, byte_addr and rd_data line up without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= 8'd0;
            blk_dout <= 8'd0;
        end else begin
            if (state_next == RD_STREAM) begin
                rd_data <= mem[cnt_next[8:0]];
            end
            if (blk_ack && (state == WR_REQ || state == WR_DRAIN)) begin
                blk_dout <= mem[blk_addr];
            end
        end
    end

endmodule

// File: tb/tb_floppy_sd_responder.sv
// tb_floppy_sd_responder
// Directed bench for floppy_sd_responder: read/write paths, arbitration,
// ack timeout, reset mid-stream and back-to-back transfers. Inputs change
// 1 ns after the rising edge; outputs are sampled at the same point.

module tb_floppy_sd_responder;

    localparam int WR_LAT      = 1;
    localparam int ACK_TIMEOUT = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] req_lba = '0;
    logic [1:0]  req_rd = '0;
    logic [1:0]  req_wr = '0;
    logic        busy;
    logic        done;
    logic [8:0]  byte_addr;
    logic        byte_en;
    logic [7:0]  rd_data;
    logic [7:0]  wr_data = '0;
    logic [10:0] blk_lba;
    logic [1:0]  blk_sel;
    logic        blk_rd;
    logic        blk_wr;
    logic        blk_ack = 1'b0;
    logic [8:0]  blk_addr = '0;
    logic [7:0]  blk_din = '0;
    logic        blk_din_we = 1'b0;
    logic [7:0]  blk_dout;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    floppy_sd_responder #(
        .WR_LAT      (WR_LAT),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_lba    (req_lba),
        .req_rd     (req_rd),
        .req_wr     (req_wr),
        .busy       (busy),
        .done       (done),
        .byte_addr  (byte_addr),
        .byte_en    (byte_en),
        .rd_data    (rd_data),
        .wr_data    (wr_data),
        .blk_lba    (blk_lba),
        .blk_sel    (blk_sel),
        .blk_rd     (blk_rd),
        .blk_wr     (blk_wr),
        .blk_ack    (blk_ack),
        .blk_addr   (blk_addr),
        .blk_din    (blk_din),
        .blk_din_we (blk_din_we),
        .blk_dout   (blk_dout),
        .err        (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Clock until busy rises; gap = cycles spent with busy low.
    task automatic wait_accept(input string tag, output int gap);
        gap = 0;
        do begin
            tick();
            gap++;
            if (gap == 1) check_val({tag, "_done_pulse"}, 32'(done), 32'd0);
        end while (!busy && gap < 20);
        check_val({tag, "_accept"}, 32'(busy), 32'd1);
        check_val({tag, "_err_clr"}, 32'(err), 32'd0);
    endtask

    task automatic rd_xfer(input string tag, input logic [1:0] nrd, input logic [1:0] nwr,
                           input logic [1:0] exp_sel, input logic [10:0] exp_lba,
                           input logic [7:0] xr, input int abort_at, output int gap);
        int   n_en;
        int   nbad;
        int   rises;
        int   n;
        logic prev_en;
        wait_accept(tag, gap);
        req_rd = nrd;
        req_wr = nwr;
        check_val({tag, "_sel"}, 32'(blk_sel), 32'(exp_sel));
        check_val({tag, "_lba"}, 32'(blk_lba), 32'(exp_lba));
        check_val({tag, "_blk_rd"}, 32'(blk_rd), 32'd1);
        check_val({tag, "_blk_wr"}, 32'(blk_wr), 32'd0);
        repeat (3) tick();
        check_val({tag, "_rd_hold"}, 32'(blk_rd), 32'd1);
        blk_ack    = 1'b1;
        blk_din_we = 1'b1;
        for (int i = 0; i < 512; i++) begin
            blk_addr = 9'(i);
            blk_din  = 8'(i) ^ xr;
            tick();
            if (i == 0) check_val({tag, "_rd_drop"}, 32'(blk_rd), 32'd0);
        end
        // strobe while ack is low must not touch byte 5
        blk_ack  = 1'b0;
        blk_addr = 9'd5;
        blk_din  = 8'hEE;
        tick();
        blk_din_we = 1'b0;
        n_en = 0; nbad = 0; rises = 0; prev_en = 1'b0; n = 0;
        while (!done && n < 700) begin
            if (byte_en) begin
                if (!prev_en) rises++;
                if (byte_addr !== 9'(n_en) || rd_data !== (8'(n_en) ^ xr)) nbad++;
                if (n_en == abort_at) begin
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    check_val({tag, "_rst_busy"}, 32'(busy), 32'd0);
                    check_val({tag, "_rst_en"}, 32'(byte_en), 32'd0);
                    check_val({tag, "_rst_done"}, 32'(done), 32'd0);
                    check_val({tag, "_pre_bad"}, 32'(nbad), 32'd0);
                    return;
                end
                n_en++;
            end
            prev_en = byte_en;
            tick();
            n++;
        end
        check_val({tag, "_done"}, 32'(done), 32'd1);
        check_val({tag, "_busy_low"}, 32'(busy), 32'd0);
        check_val({tag, "_last_en"}, 32'(prev_en), 32'd1);
        check_val({tag, "_en_count"}, 32'(n_en), 32'd512);
        check_val({tag, "_en_runs"}, 32'(rises), 32'd1);
        check_val({tag, "_data_bad"}, 32'(nbad), 32'd0);
        check_val({tag, "_addr_fin"}, 32'(byte_addr), 32'd0);
        check_val({tag, "_lba_hold"}, 32'(blk_lba), 32'(exp_lba));
        check_val({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic wr_xfer(input string tag, input logic [1:0] nrd, input logic [1:0] nwr,
                           input logic [1:0] exp_sel, input logic [10:0] exp_lba,
                           input logic [7:0] add, output int gap);
        int         n;
        int         nbad;
        int         n_en;
        int         max_addr;
        logic [8:0] prev_addr;
        wait_accept(tag, gap);
        req_rd = nrd;
        req_wr = nwr;
        check_val({tag, "_sel"}, 32'(blk_sel), 32'(exp_sel));
        check_val({tag, "_lba"}, 32'(blk_lba), 32'(exp_lba));
        check_val({tag, "_blk_rd"}, 32'(blk_rd), 32'd0);
        check_val({tag, "_addr0"}, 32'(byte_addr), 32'd0);
        prev_addr = byte_addr;
        max_addr  = 0;
        n_en      = 0;
        n         = 0;
        while (!blk_wr && n < 700) begin
            tick();
            n++;
            wr_data = 8'(prev_addr) + add;
            if (byte_en) n_en++;
            if (int'(byte_addr) > max_addr) max_addr = int'(byte_addr);
            prev_addr = byte_addr;
        end
        check_val({tag, "_gather_len"}, 32'(n), 32'(512 + WR_LAT));
        check_val({tag, "_max_addr"}, 32'(max_addr), 32'd511);
        repeat (2) tick();
        check_val({tag, "_wr_hold"}, 32'(blk_wr), 32'd1);
        blk_ack = 1'b1;
        nbad    = 0;
        for (int a = 0; a < 512; a++) begin
            blk_addr = 9'(a);
            tick();
            if (a == 0) check_val({tag, "_wr_drop"}, 32'(blk_wr), 32'd0);
            if (blk_dout !== 8'(a) + add) nbad++;
            if (byte_en) n_en++;
        end
        blk_ack = 1'b0;
        n = 0;
        while (!done && n < 10) begin
            tick();
            n++;
        end
        check_val({tag, "_done"}, 32'(done), 32'd1);
        check_val({tag, "_done_lat"}, 32'(n), 32'd1);
        check_val({tag, "_busy_low"}, 32'(busy), 32'd0);
        check_val({tag, "_dout_bad"}, 32'(nbad), 32'd0);
        check_val({tag, "_no_en"}, 32'(n_en), 32'd0);
        check_val({tag, "_lba_hold"}, 32'(blk_lba), 32'(exp_lba));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int gap;
        int n;
        int n_en;

        repeat (3) tick();
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_byte_en", 32'(byte_en), 32'd0);
        check_val("rst_blk_rd", 32'(blk_rd), 32'd0);
        check_val("rst_blk_wr", 32'(blk_wr), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        check_val("rst_byte_addr", 32'(byte_addr), 32'd0);
        check_val("rst_rd_data", 32'(rd_data), 32'd0);
        check_val("rst_blk_lba", 32'(blk_lba), 32'd0);
        check_val("rst_blk_sel", 32'(blk_sel), 32'd0);
        check_val("rst_blk_dout", 32'(blk_dout), 32'd0);
        rst = 1'b0;
        tick();

        // read path
        req_rd  = 2'b01;
        req_lba = 11'h123;
        rd_xfer("rd", 2'b00, 2'b00, 2'b01, 11'h123, 8'h5A, -1, gap);

        // write path
        tick();
        req_wr  = 2'b10;
        req_lba = 11'd7;
        wr_xfer("wr", 2'b00, 2'b00, 2'b10, 11'd7, 8'd3, gap);

        // arbitration: read drive 0, then held read drive 1, then held write drive 0
        tick();
        req_rd  = 2'b11;
        req_wr  = 2'b01;
        req_lba = 11'h3C1;
        rd_xfer("arb0", 2'b10, 2'b01, 2'b01, 11'h3C1, 8'h11, -1, gap);
        req_lba = 11'h3C2;
        rd_xfer("arb1", 2'b00, 2'b01, 2'b10, 11'h3C2, 8'h22, -1, gap);
        check_val("arb1_gap", 32'(gap), 32'd1);
        req_lba = 11'h3C3;
        wr_xfer("arb2", 2'b00, 2'b00, 2'b01, 11'h3C3, 8'h40, gap);
        check_val("arb2_gap", 32'(gap), 32'd1);

        // ack timeout on a read
        tick();
        req_rd  = 2'b01;
        req_lba = 11'h055;
        wait_accept("to", gap);
        req_rd = 2'b00;
        n    = 0;
        n_en = 0;
        while (blk_rd && n < 200) begin
            n++;
            tick();
            if (byte_en) n_en++;
        end
        check_val("to_rd_len", 32'(n), 32'd100);
        check_val("to_done", 32'(done), 32'd1);
        check_val("to_err", 32'(err), 32'd1);
        repeat (5) begin
            tick();
            if (byte_en) n_en++;
        end
        check_val("to_err_sticky", 32'(err), 32'd1);
        check_val("to_busy", 32'(busy), 32'd0);
        check_val("to_no_en", 32'(n_en), 32'd0);
        req_rd  = 2'b01;
        req_lba = 11'h0AB;
        rd_xfer("to_next", 2'b00, 2'b00, 2'b01, 11'h0AB, 8'h33, -1, gap);

        // reset at byte 200 of the stream, then a fresh read
        tick();
        req_rd  = 2'b01;
        req_lba = 11'h200;
        rd_xfer("abort", 2'b00, 2'b00, 2'b01, 11'h200, 8'h77, 200, gap);
        tick();
        req_rd  = 2'b10;
        req_lba = 11'h201;
        rd_xfer("fresh", 2'b00, 2'b00, 2'b10, 11'h201, 8'hC3, -1, gap);

        // back-to-back reads raised in the done cycle
        tick();
        req_rd  = 2'b01;
        req_lba = 11'h010;
        rd_xfer("b2b0", 2'b00, 2'b00, 2'b01, 11'h010, 8'hA5, -1, gap);
        req_rd  = 2'b01;
        req_lba = 11'h011;
        rd_xfer("b2b1", 2'b00, 2'b00, 2'b01, 11'h011, 8'h0F, -1, gap);
        check_val("b2b1_gap", 32'(gap), 32'd1);
        req_rd  = 2'b10;
        req_lba = 11'h012;
        rd_xfer("b2b2", 2'b00, 2'b00, 2'b10, 11'h012, 8'hF0, -1, gap);
        check_val("b2b2_gap", 32'(gap), 32'd1);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
